// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and defaults for the image ROM port arbiter
package rom_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_HOST = 2'd2
  } tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } host_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 24;

endpackage

// File: rtl/rom_tag_pipe.sv
// rtl/rom_tag_pipe.sv - requester tag delay line aligned with ROM read latency
module rom_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) stages[i] <= TAG_NONE;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[RD_LATENCY-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares the image ROM between the VGA scan path and a host read port
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              vga_pixel_valid,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_starved,
  input  logic              clr_starved,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  host_state_t       state;
  tag_t              grant_tag;
  tag_t              out_tag;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  wait_cnt;

  // Scan path always wins; the host only gets idle cycles, one read at a time.
  always_comb begin
    rom_address = addr_q;
    grant_tag   = TAG_NONE;
    host_ack    = 1'b0;
    if (!rst) begin
      rom_address = '0;
    end else if (vga_req) begin
      rom_address = vga_addr;
      grant_tag   = TAG_VGA;
    end else if (state == IDLE && host_req) begin
      rom_address = host_addr;
      grant_tag   = TAG_HOST;
      host_ack    = 1'b1;
    end
  end

  rom_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (grant_tag),
    .tag_out(out_tag)
  );

  assign vga_pixel_valid = (out_tag == TAG_VGA);
  assign vga_pixel       = vga_pixel_valid ? rom_q : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      host_starved <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      addr_q      <= rom_address;
      host_rvalid <= (out_tag == TAG_HOST);
      if (out_tag == TAG_HOST) host_rdata <= rom_q;

      case (state)
        IDLE: if (host_ack) state <= WAIT;
        WAIT: if (host_rvalid) state <= IDLE;
      endcase

      if (!host_req || host_ack) begin
        wait_cnt <= '0;
      end else if (state == IDLE && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // A pending starvation set overrides a same-cycle clear.
      if (wait_cnt == CNT_MAX) begin
        host_starved <= 1'b1;
      end else if (clr_starved) begin
        host_starved <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed vector bench for rom_port_arbiter
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        host_req;
  logic [15:0] host_addr;
  logic        clr_starved;

  logic [23:0] pix1, pix3, rdata1, rdata3, q1, q3;
  logic        pv1, pv3, ack1, ack3, rv1, rv3, st1, st3;
  logic [15:0] ra1, ra3;
  logic [15:0] m1_a, m3_a, m3_b, m3_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_pixel(pix1), .vga_pixel_valid(pv1), .host_req(host_req),
    .host_addr(host_addr), .host_ack(ack1), .host_rdata(rdata1),
    .host_rvalid(rv1), .host_starved(st1), .clr_starved(clr_starved),
    .rom_address(ra1), .rom_q(q1)
  );

  rom_port_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_pixel(pix3), .vga_pixel_valid(pv3), .host_req(host_req),
    .host_addr(host_addr), .host_ack(ack3), .host_rdata(rdata3),
    .host_rvalid(rv3), .host_starved(st3), .clr_starved(clr_starved),
    .rom_address(ra3), .rom_q(q3)
  );

  // ROM models return the zero-extended address after the configured latency.
  always @(posedge clk) begin
    m1_a <= ra1;
    m3_a <= ra3;
    m3_b <= m3_a;
    m3_c <= m3_b;
  end
  assign q1 = {8'h00, m1_a};
  assign q3 = {8'h00, m3_c};

  typedef struct {
    logic        rst;
    logic        vreq;
    logic [15:0] va;
    logic        hreq;
    logic [15:0] ha;
    logic [15:0] e_rom;
    logic        e_ack;
    logic        e_vv;
    logic [23:0] e_pix;
    logic        e_rv;
    logic [23:0] e_rd;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        v_iss [64];
  logic [15:0] v_adr [64];
  logic        h_wait;
  int          h_due;
  logic [15:0] h_cur, h_exp, last_rom, e_rom;
  logic        e_ack, e_vv, e_rv;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'h5555, 1'b1, 16'h7777, 16'h0000, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0};
    tbl[1]  = '{1'b0, 1'b1, 16'h5555, 1'b1, 16'h7777, 16'h0000, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0};
    tbl[2]  = '{1'b0, 1'b1, 16'h5555, 1'b1, 16'h7777, 16'h0000, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0123, 1'b0, 16'h0000, 16'h0123, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0123, 1'b0, 1'b1, 24'h000123, 1'b0, 24'h0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 24'h0, 1'b1, 24'h00BEEF};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h1234, 1'b1, 1'b0, 24'h0, 1'b0, 24'h00BEEF};
    tbl[9]  = '{1'b1, 1'b1, 16'h0AAA, 1'b1, 16'h2222, 16'h0AAA, 1'b0, 1'b0, 24'h0, 1'b0, 24'h00BEEF};
    tbl[10] = '{1'b1, 1'b1, 16'h0BBB, 1'b1, 16'h2222, 16'h0BBB, 1'b0, 1'b1, 24'h000AAA, 1'b1, 24'h001234};
    tbl[11] = '{1'b1, 1'b1, 16'h0CCC, 1'b1, 16'h2222, 16'h0CCC, 1'b0, 1'b1, 24'h000BBB, 1'b0, 24'h001234};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'h2222, 1'b1, 1'b1, 24'h000CCC, 1'b0, 24'h001234};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h2222, 1'b0, 1'b0, 24'h0, 1'b0, 24'h001234};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h2222, 1'b0, 1'b0, 24'h0, 1'b1, 24'h002222};
    tbl[15] = '{1'b1, 1'b1, 16'h0DDD, 1'b1, 16'h3333, 16'h0DDD, 1'b0, 1'b0, 24'h0, 1'b0, 24'h002222};
    tbl[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h3333, 16'h0DDD, 1'b0, 1'b1, 24'h000DDD, 1'b0, 24'h002222};
    tbl[17] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0DDD, 1'b0, 1'b0, 24'h0, 1'b0, 24'h002222};
    tbl[18] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h4444, 16'h4444, 1'b1, 1'b0, 24'h0, 1'b0, 24'h002222};
    tbl[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 24'h0, 1'b0, 24'h002222};
    tbl[20] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'h5555, 1'b1, 1'b0, 24'h0, 1'b0, 24'h000000};
    tbl[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0, 24'h0, 1'b0, 24'h000000};
    tbl[22] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0, 24'h0, 1'b1, 24'h005555};

    clr_starved = 1'b0;
    for (int i = 0; i < 23; i++) begin
      rst       = tbl[i].rst;
      vga_req   = tbl[i].vreq;
      vga_addr  = tbl[i].va;
      host_req  = tbl[i].hreq;
      host_addr = tbl[i].ha;
      @(negedge clk);
      chk($sformatf("row%0d rom_address", i), 32'(ra1), 32'(tbl[i].e_rom));
      chk($sformatf("row%0d host_ack", i), 32'(ack1), 32'(tbl[i].e_ack));
      chk($sformatf("row%0d vga_pixel_valid", i), 32'(pv1), 32'(tbl[i].e_vv));
      chk($sformatf("row%0d vga_pixel", i), 32'(pix1), 32'(tbl[i].e_pix));
      chk($sformatf("row%0d host_rvalid", i), 32'(rv1), 32'(tbl[i].e_rv));
      chk($sformatf("row%0d host_rdata", i), 32'(rdata1), 32'(tbl[i].e_rd));
      chk($sformatf("row%0d host_starved", i), 32'(st1), 32'h0);
      @(posedge clk);
      #1;
    end

    // Starvation: scan path holds the ROM while the host keeps asking.
    vga_req   = 1'b1;
    vga_addr  = 16'h0777;
    host_req  = 1'b1;
    host_addr = 16'h6666;
    repeat (800) @(posedge clk);
    @(negedge clk);
    chk("starve 800 host_ack", 32'(ack1), 32'h0);
    chk("starve 800 host_starved", 32'(st1), 32'h0);
    repeat (224) @(posedge clk);
    @(negedge clk);
    chk("starve 1024 host_starved", 32'(st1), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("starve 1025 host_starved", 32'(st1), 32'h1);
    clr_starved = 1'b1;
    @(posedge clk);
    #1;
    clr_starved = 1'b0;
    @(negedge clk);
    chk("clr while saturated host_starved", 32'(st1), 32'h1);
    vga_req = 1'b0;
    #1;
    chk("ack on vga drop host_ack", 32'(ack1), 32'h1);
    chk("ack on vga drop rom_address", 32'(ra1), 32'h6666);
    @(posedge clk);
    #1;
    host_req    = 1'b0;
    clr_starved = 1'b1;
    @(posedge clk);
    #1;
    clr_starved = 1'b0;
    @(negedge clk);
    chk("clr after ack host_starved", 32'(st1), 32'h0);

    // Alternating scan/host traffic on the three-cycle latency instance.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    h_wait   = 1'b0;
    h_due    = -1;
    h_cur    = 16'hC000;
    h_exp    = 16'h0000;
    last_rom = 16'h0000;
    for (int i = 0; i < 48; i++) begin
      vga_req   = i[0];
      vga_addr  = 16'h0100 + 16'(i);
      host_req  = 1'b1;
      host_addr = h_cur;
      e_ack = !vga_req && !h_wait;
      e_rom = vga_req ? vga_addr : (e_ack ? host_addr : last_rom);
      e_vv  = (i >= 3) ? v_iss[i-3] : 1'b0;
      e_rv  = h_wait && (i == h_due);
      v_iss[i] = vga_req;
      v_adr[i] = vga_addr;
      @(negedge clk);
      chk($sformatf("alt%0d host_ack", i), 32'(ack3), 32'(e_ack));
      chk($sformatf("alt%0d rom_address", i), 32'(ra3), 32'(e_rom));
      chk($sformatf("alt%0d vga_pixel_valid", i), 32'(pv3), 32'(e_vv));
      chk($sformatf("alt%0d host_rvalid", i), 32'(rv3), 32'(e_rv));
      if (e_vv) chk($sformatf("alt%0d vga_pixel", i), 32'(pix3), {16'h0, v_adr[i-3]});
      if (e_rv) chk($sformatf("alt%0d host_rdata", i), 32'(rdata3), {16'h0, h_exp});
      if (e_ack) begin
        h_wait = 1'b1;
        h_due  = i + 4;
        h_exp  = host_addr;
        h_cur  = h_cur + 16'h0011;
      end
      if (e_rv) h_wait = 1'b0;
      last_rom = e_rom;
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
